// File: rtl/dot_matrix_pkg.sv
// Shared constants and scanner state encoding for the 16x16 dot matrix driver.
package dot_matrix_pkg;

  localparam int DM_ROWS  = 16;
  localparam int DM_COLS  = 16;
  localparam int DM_ROW_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  // One-hot row select for a binary row index.
  function automatic logic [DM_ROWS-1:0] row_onehot(input logic [DM_ROW_W-1:0] idx);
    logic [DM_ROWS-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dot_matrix_scanner_tick_gen.sv
// Scan tick prescaler: one-clk tick every DIV clks while run is high.
// The count is forced to zero whenever run is low, so every run period
// starts with a full DIV-clk interval before the first tick.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = run && (cnt_q == CW'(DIV - 1));

  // Prescaler: clear when stopped, wrap on tick, otherwise count up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!run || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/dot_matrix_scanner.sv
// Sequential scan driver for a 16x16 LED dot matrix.
// Steps row_bin through the pattern ROM, captures the returned column word at
// the end of each blanking gap, then lights that row for SHOW_TICKS ticks.
// Optional build macro DOT_MATRIX_SCANNER_DIM_EN adds a dim[1:0] input that
// shortens the part of SHOW during which the columns are driven.
// Interface: en is a level enable; dropping it returns to IDLE on the next clk
// with all outputs cleared, and re-enabling always restarts at row 0.
module dot_matrix_scanner
  import dot_matrix_pkg::*;
#(
  parameter int DIV         = 4,
  parameter int BLANK_TICKS = 1,
  parameter int SHOW_TICKS  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
`ifdef DOT_MATRIX_SCANNER_DIM_EN
  input  logic [1:0]          dim,
`endif
  input  logic [DM_COLS-1:0]  col_in,
  output logic [DM_ROW_W-1:0] row_bin,
  output logic [DM_ROWS-1:0]  row,
  output logic [DM_COLS-1:0]  col,
  output logic                frame_done
);

  localparam int MAX_T = (BLANK_TICKS > SHOW_TICKS) ? BLANK_TICKS : SHOW_TICKS;
  localparam int PH_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  scan_state_e         state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [DM_ROW_W-1:0] row_bin_q, row_bin_d;
  logic [DM_ROWS-1:0]  row_q, row_d;
  logic [DM_COLS-1:0]  col_q, col_d;
  logic [DM_COLS-1:0]  cap_q, cap_d;
  logic                frame_done_q, frame_done_d;
  logic [31:0]         show_lim;
  logic                run;
  logic                tick;

  // Prescaler only runs while actively scanning.
  assign run = en && (state_q != IDLE);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: phase counter, row index, captured word and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= '0;
      row_bin_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      cap_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      row_bin_q    <= row_bin_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cap_q        <= cap_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state and next-output logic; col is derived from the next state so
  // the column register never holds data outside SHOW.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    row_bin_d    = row_bin_q;
    row_d        = row_q;
    cap_d        = cap_q;
    frame_done_d = 1'b0;
    col_d        = '0;
`ifdef DOT_MATRIX_SCANNER_DIM_EN
    show_lim     = 32'(SHOW_TICKS) >> dim;
`else
    show_lim     = 32'(SHOW_TICKS);
`endif

    if (!en) begin
      state_d   = IDLE;
      phase_d   = '0;
      row_bin_d = '0;
      row_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = BLANK;
          phase_d   = '0;
          row_bin_d = '0;
          row_d     = '0;
        end
        BLANK: begin
          row_d = '0;
          if (tick) begin
            if (phase_q == PH_W'(BLANK_TICKS - 1)) begin
              // ROM output has been stable for the whole gap; capture it.
              cap_d   = col_in;
              row_d   = row_onehot(row_bin_q);
              phase_d = '0;
              state_d = SHOW;
            end else begin
              phase_d = phase_q + PH_W'(1);
            end
          end
        end
        SHOW: begin
          if (tick) begin
            if (phase_q == PH_W'(SHOW_TICKS - 1)) begin
              row_d        = '0;
              phase_d      = '0;
              row_bin_d    = row_bin_q + DM_ROW_W'(1);
              state_d      = BLANK;
              frame_done_d = (row_bin_q == DM_ROW_W'(DM_ROWS - 1));
            end else begin
              phase_d = phase_q + PH_W'(1);
            end
          end
        end
        default: begin
          state_d   = IDLE;
          phase_d   = '0;
          row_bin_d = '0;
          row_d     = '0;
        end
      endcase
    end

    if ((state_d == SHOW) && (32'(phase_d) < show_lim)) begin
      col_d = cap_d;
    end
  end

  assign row_bin    = row_bin_q;
  assign row        = row_q;
  assign col        = col_q;
  assign frame_done = frame_done_q;

endmodule
